// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the elastic shift-register pipeline.
package pipeline_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;

    typedef logic [DEF_DATA_WIDTH-1:0] lane_t;

    // Width needed to hold the values 0..n inclusive.
    function automatic int unsigned clog2p1(input int unsigned n);
        if (n == 0) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipeline_stage.sv
// One valid+data slot of the elastic pipeline; data only loads on a valid arrival.
module pipeline_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             adv,
    input  logic             in_v,
    input  logic [WIDTH-1:0] in_d,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    logic             v_q;
    logic             v_d;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_d;

    // Flush clears the valid and leaves data untouched; otherwise move only when advancing.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (adv) begin
            v_d = in_v;
            if (in_v) begin
                d_d = in_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v = v_q;
    assign d = d_q;

endmodule

// File: rtl/pipeline_shift_elastic.sv
// Fixed-latency multi-lane delay line with valid/ready backpressure, bubble collapse and flush.
module pipeline_shift_elastic
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 1,
    parameter int unsigned PIPELINE_N = 2,
    localparam int unsigned CNT_W     = clog2p1(PIPELINE_N)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]             count
);

    localparam int unsigned BUS_W = NUM_CH * DATA_WIDTH;

    if (PIPELINE_N < 1) begin : g_bad_depth
        $error("pipeline_shift_elastic: PIPELINE_N must be >= 1");
    end

    logic [PIPELINE_N-1:0] valid_q;
    logic [PIPELINE_N-1:0] adv_c;
    logic [PIPELINE_N-1:0] stage_in_v_c;
    logic [BUS_W-1:0]      data_q       [PIPELINE_N];
    logic [BUS_W-1:0]      stage_in_d_c [PIPELINE_N];
    logic                  accept_c;
    logic                  xfer_c;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;

    // A stage may advance when some stage at or after it is empty, or the output drains.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        adv_c    = '0;
        for (int i = int'(PIPELINE_N) - 1; i >= 0; i--) begin
            all_full = all_full & valid_q[i];
            adv_c[i] = ~all_full | out_ready;
        end
    end

    assign in_ready  = rst_n & adv_c[0] & ~flush;
    assign accept_c  = in_valid & in_ready;
    assign xfer_c    = valid_q[PIPELINE_N-1] & out_ready;
    assign out_valid = valid_q[PIPELINE_N-1];
    assign out_data  = data_q[PIPELINE_N-1];
    assign count     = count_q;

    for (genvar i = 0; i < int'(PIPELINE_N); i++) begin : g_stage
        if (i == 0) begin : g_head
            assign stage_in_v_c[i] = accept_c;
            assign stage_in_d_c[i] = in_data;
        end else begin : g_body
            assign stage_in_v_c[i] = valid_q[i-1];
            assign stage_in_d_c[i] = data_q[i-1];
        end

        pipeline_stage #(
            .WIDTH (BUS_W)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .adv   (adv_c[i]),
            .in_v  (stage_in_v_c[i]),
            .in_d  (stage_in_d_c[i]),
            .v     (valid_q[i]),
            .d     (data_q[i])
        );
    end

    // Occupancy tracks popcount(valid_q) incrementally.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case ({accept_c, xfer_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
